// File: rtl/bp_pkg.sv
// Shared types and defaults for the gshare/bimodal branch predictor.
// Build option: BP_GSHARE_EN selects gshare indexing; otherwise bimodal.
package bp_pkg;

    localparam int DBITS        = 32;
    localparam int BHR_BITS     = 8;
    localparam int BTB_IDX_BITS = 4;
    localparam int BTB_TAG_BITS = DBITS - BTB_IDX_BITS - 2;

    typedef logic [1:0] pht_ctr_t;

    localparam pht_ctr_t PHT_WNT = 2'b01;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_t;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [DBITS-1:0]        target;
        logic                    is_jmp;
    } btb_entry_t;

    // Two-bit saturating counter step, pinned at 0 and 3.
    function automatic pht_ctr_t pht_sat_step(input pht_ctr_t ctr, input logic taken);
        pht_ctr_t nxt;
        nxt = ctr;
        if (taken && (ctr != 2'b11)) begin
            nxt = ctr + 2'd1;
        end else if (!taken && (ctr != 2'b00)) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table with post-reset init sweep; ready goes high once every
// entry has been written to weakly-not-taken.
//
// state | meaning
// INIT  | sweeping PHT[cnt] <= 01, one entry per cycle; updates ignored
// RUN   | table valid, training updates accepted
module bp_pht
    import bp_pkg::*;
#(
    parameter int IDX_BITS = bp_pkg::BHR_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output pht_ctr_t            o_rd_ctr,
    input  logic                i_upd_en,
    input  logic [IDX_BITS-1:0] i_upd_idx,
    input  logic                i_upd_taken,
    output logic                o_ready
);

    localparam int                DEPTH   = 1 << IDX_BITS;
    localparam logic [IDX_BITS-1:0] CNT_ONE = {{(IDX_BITS-1){1'b0}}, 1'b1};

    bp_state_t           r_state;
    bp_state_t           w_state_nxt;
    logic [IDX_BITS-1:0] r_sweep_cnt;
    logic                w_sweep;
    pht_ctr_t            r_pht [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (r_sweep_cnt == '1) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    always_comb begin
        w_sweep = (r_state == INIT);
        o_ready = (r_state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep_cnt <= '0;
        end else if (w_sweep) begin
            r_sweep_cnt <= r_sweep_cnt + CNT_ONE;
        end
    end

    // No reset on the array itself: the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (w_sweep) begin
            r_pht[r_sweep_cnt] <= PHT_WNT;
        end else if (i_upd_en) begin
            r_pht[i_upd_idx] <= pht_sat_step(r_pht[i_upd_idx], i_upd_taken);
        end
    end

    assign o_rd_ctr = r_pht[i_rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: PHT (bp_pht) plus direct-mapped BTB and global history.
// Build option: BP_GSHARE_EN enables the history register; undefined gives bimodal indexing.
module branch_predictor #(
    parameter int DBITS        = bp_pkg::DBITS,
    parameter int BHR_BITS     = bp_pkg::BHR_BITS,
    parameter int BTB_IDX_BITS = bp_pkg::BTB_IDX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DBITS-1:0]    PC_FE,
    output logic [DBITS-1:0]    pcnext_FE,
    output logic                pred_taken_FE,
    output logic [BHR_BITS-1:0] pc_xor_bhr_FE,
    output logic                ready,
    input  logic                upd_valid_AGEX,
    input  logic                is_br_AGEX,
    input  logic                is_jmp_AGEX,
    input  logic                do_brjmp_AGEX,
    input  logic [DBITS-1:0]    PC_AGEX,
    input  logic [DBITS-1:0]    br_target_AGEX,
    input  logic [BHR_BITS-1:0] pc_xor_bhr_AGEX
);
    import bp_pkg::*;

    localparam int BTB_DEPTH = 1 << BTB_IDX_BITS;
    localparam int TAG_LSB   = BTB_IDX_BITS + 2;
    localparam int TAG_W     = DBITS - TAG_LSB;

    logic [BHR_BITS-1:0]     w_bhr;
    logic                    w_ready;
    pht_ctr_t                w_pht_ctr;
    logic                    w_upd;
    logic                    w_upd_br;
    logic                    w_btb_we;
    logic [BTB_IDX_BITS-1:0] w_fe_btb_idx;
    logic [BTB_IDX_BITS-1:0] w_ag_btb_idx;
    logic [TAG_W-1:0]        w_fe_tag;
    btb_entry_t              w_fe_entry;
    btb_entry_t              w_wr_entry;
    logic                    w_hit;
    logic [DBITS-1:0]        w_pc_plus4;
    btb_entry_t              r_btb [BTB_DEPTH];
    logic                    w_unused;

    assign w_upd    = w_ready && upd_valid_AGEX;
    assign w_upd_br = w_upd && is_br_AGEX;
    assign w_btb_we = w_upd && do_brjmp_AGEX;

    assign pc_xor_bhr_FE = PC_FE[BHR_BITS+1:2] ^ w_bhr;

    bp_pht #(
        .IDX_BITS (BHR_BITS)
    ) u_pht (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (pc_xor_bhr_FE),
        .o_rd_ctr    (w_pht_ctr),
        .i_upd_en    (w_upd_br),
        .i_upd_idx   (pc_xor_bhr_AGEX),
        .i_upd_taken (do_brjmp_AGEX),
        .o_ready     (w_ready)
    );

`ifdef BP_GSHARE_EN
    logic [BHR_BITS-1:0] r_bhr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bhr <= '0;
        end else if (w_upd_br) begin
            r_bhr <= {r_bhr[BHR_BITS-2:0], do_brjmp_AGEX};
        end
    end

    assign w_bhr = r_bhr;
`else
    assign w_bhr = '0;
`endif

    assign w_fe_btb_idx = PC_FE[BTB_IDX_BITS+1:2];
    assign w_ag_btb_idx = PC_AGEX[BTB_IDX_BITS+1:2];
    assign w_fe_tag     = PC_FE[DBITS-1:TAG_LSB];
    assign w_fe_entry   = r_btb[w_fe_btb_idx];

    always_comb begin
        w_wr_entry        = '0;
        w_wr_entry.valid  = 1'b1;
        w_wr_entry.tag    = PC_AGEX[DBITS-1:TAG_LSB];
        w_wr_entry.target = br_target_AGEX;
        w_wr_entry.is_jmp = is_jmp_AGEX;
    end

    // Only valid bits are cleared on reset; stale tag/target are masked by valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_btb[i].valid <= 1'b0;
            end
        end else if (w_btb_we) begin
            r_btb[w_ag_btb_idx] <= w_wr_entry;
        end
    end

    assign w_pc_plus4 = PC_FE + DBITS'(4);

    always_comb begin
        w_hit         = w_ready && w_fe_entry.valid && (w_fe_entry.tag == w_fe_tag);
        pred_taken_FE = w_hit && (w_fe_entry.is_jmp || w_pht_ctr[1]);
        pcnext_FE     = pred_taken_FE ? w_fe_entry.target : w_pc_plus4;
        ready         = w_ready;
    end

    assign w_unused = ^{PC_FE[1:0], PC_AGEX[1:0], w_pht_ctr[0]};

endmodule

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_FE;
    logic [31:0] pcnext_FE;
    logic        pred_taken_FE;
    logic [7:0]  pc_xor_bhr_FE;
    logic        ready;
    logic        upd_valid_AGEX;
    logic        is_br_AGEX;
    logic        is_jmp_AGEX;
    logic        do_brjmp_AGEX;
    logic [31:0] PC_AGEX;
    logic [31:0] br_target_AGEX;
    logic [7:0]  pc_xor_bhr_AGEX;

    branch_predictor #(
        .DBITS        (32),
        .BHR_BITS     (8),
        .BTB_IDX_BITS (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .PC_FE           (PC_FE),
        .pcnext_FE       (pcnext_FE),
        .pred_taken_FE   (pred_taken_FE),
        .pc_xor_bhr_FE   (pc_xor_bhr_FE),
        .ready           (ready),
        .upd_valid_AGEX  (upd_valid_AGEX),
        .is_br_AGEX      (is_br_AGEX),
        .is_jmp_AGEX     (is_jmp_AGEX),
        .do_brjmp_AGEX   (do_brjmp_AGEX),
        .PC_AGEX         (PC_AGEX),
        .br_target_AGEX  (br_target_AGEX),
        .pc_xor_bhr_AGEX (pc_xor_bhr_AGEX)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain arrays indexed from PC arithmetic.
    int          m_pht [256];
    bit          m_v   [16];
    logic [31:0] m_pc  [16];
    logic [31:0] m_tgt [16];
    bit          m_jmp [16];
    int          m_bhr;
    int          m_cnt;

    logic        obs_pred;
    logic        obs_ready;
    logic [31:0] obs_next;
    logic [7:0]  obs_idx;

    typedef struct packed {
        logic        uv;
        logic        ib;
        logic        ij;
        logic        dt;
        logic [31:0] pcu;
        logic [31:0] tgt;
        logic [31:0] pcfe;
        logic        ep;
        logic [31:0] en;
    } vec_t;

    vec_t tbl [0:30];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_bhr = 0;
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
    endtask

    // One clock: drive, check outputs at negedge against the model, then advance the model.
    task automatic cyc(input bit r, input bit uv, input bit ib, input bit ij, input bit dt,
                       input logic [31:0] pcu, input logic [31:0] tgt, input logic [31:0] pcfe);
        int idx, bi, aidx, ab;
        bit mready, hit, mpred;
        logic [31:0] mnext;
        aidx = int'(((pcu >> 2) ^ m_bhr) & 255);
        ab   = int'((pcu >> 2) & 15);
        rst = r; upd_valid_AGEX = uv; is_br_AGEX = ib; is_jmp_AGEX = ij; do_brjmp_AGEX = dt;
        PC_AGEX = pcu; br_target_AGEX = tgt; pc_xor_bhr_AGEX = aidx[7:0]; PC_FE = pcfe;
        @(negedge clk);
        idx    = int'(((pcfe >> 2) ^ m_bhr) & 255);
        bi     = int'((pcfe >> 2) & 15);
        mready = (m_cnt >= 256);
        hit    = mready && m_v[bi] && ((m_pc[bi] >> 6) == (pcfe >> 6));
        mpred  = hit && (m_jmp[bi] || (m_pht[idx] >= 2));
        mnext  = mpred ? m_tgt[bi] : pcfe + 32'd4;
        obs_pred = pred_taken_FE; obs_ready = ready; obs_next = pcnext_FE; obs_idx = pc_xor_bhr_FE;
        chk("ready", ready, mready);
        chk("pred_taken", pred_taken_FE, mpred);
        chk("pcnext", pcnext_FE, mnext);
        chk("pc_xor_bhr", pc_xor_bhr_FE, idx);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (mready && uv) begin
                if (ib) begin
                    if (dt && m_pht[aidx] < 3) m_pht[aidx]++;
                    if (!dt && m_pht[aidx] > 0) m_pht[aidx]--;
`ifdef BP_GSHARE_EN
                    m_bhr = ((m_bhr << 1) | int'(dt)) & 255;
`endif
                end
                if (dt) begin
                    m_v[ab] = 1'b1; m_pc[ab] = pcu; m_tgt[ab] = tgt; m_jmp[ab] = ij;
                end
            end
            if (m_cnt < 256) m_cnt++;
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] pcfe);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, pcfe);
    endtask

    function automatic logic [31:0] pick_pc();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0100;
            1: return 32'h0000_0140;
            2: return 32'h0000_0200;
            3: return 32'h0000_0308;
            4: return 32'h0000_1100;
            5: return 32'h0000_1104;
            6: return 32'hFFFF_FFFC;
            7: return 32'h0000_0000;
            default: return {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        endcase
    endfunction

    task automatic sweep_wait();
        for (int c = 0; c <= 256; c++) idle(pick_pc());
    endtask

    initial begin
        bit uv, ib, ij, dt, r;
        logic [31:0] pc_tmp;
        logic [7:0] exp_idx;
        rst = 1'b1; upd_valid_AGEX = 0; is_br_AGEX = 0; is_jmp_AGEX = 0; do_brjmp_AGEX = 0;
        PC_AGEX = 0; br_target_AGEX = 0; pc_xor_bhr_AGEX = 0; PC_FE = 0;
        @(posedge clk); #1;
        model_reset();

        for (int i = 0; i < 2; i++)
            cyc(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b1, pick_pc(), pick_pc(), pick_pc());
        chk("reset_ready", obs_ready, 1'b0);
        chk("reset_pred", obs_pred, 1'b0);

        // INIT: updates offered but dropped; ready exactly at cycle 256.
        for (int c = 0; c <= 258; c++) begin
            pc_tmp = pick_pc();
            uv = (c < 256) ? 1'($urandom) : 1'b0;
            cyc(1'b0, uv, 1'b1, 1'b0, 1'b1, pick_pc(), pick_pc(), pc_tmp);
            if (c < 256) chk("init_pcnext", obs_next, pc_tmp + 32'd4);
            if (c == 255) chk("ready_c255", obs_ready, 1'b0);
            if (c == 256) chk("ready_c256", obs_ready, 1'b1);
        end

        tbl[0]  = '{1'b1,1'b0,1'b1,1'b1, 32'h100, 32'h40,  32'h100, 1'b0, 32'h104};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h100, 1'b1, 32'h40};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b1, 32'h200, 32'h180, 32'h200, 1'b0, 32'h204};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h200, 1'b1, 32'h180};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h100, 1'b0, 32'h104};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b0, 32'h200, 32'h180, 32'h200, 1'b1, 32'h180};
        tbl[6]  = '{1'b1,1'b1,1'b0,1'b0, 32'h200, 32'h180, 32'h200, 1'b0, 32'h204};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h200, 1'b0, 32'h204};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b1, 32'h200, 32'h180, 32'h200, 1'b0, 32'h204};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b1, 32'h200, 32'h180, 32'h200, 1'b0, 32'h204};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h200, 1'b1, 32'h180};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b1, 32'hFFFFFFFC, 32'h10, 32'hFFFFFFFC, 1'b0, 32'h0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'hFFFFFFFC, 1'b1, 32'h10};
        tbl[13] = '{1'b1,1'b0,1'b1,1'b1, 32'h100, 32'h40,  32'h100, 1'b0, 32'h104};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h100, 1'b1, 32'h40};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h200, 1'b0, 32'h204};
        tbl[16] = '{1'b1,1'b1,1'b0,1'b1, 32'h308, 32'h3C0, 32'h308, 1'b0, 32'h30C};
        tbl[17] = '{1'b1,1'b1,1'b0,1'b1, 32'h308, 32'h3C0, 32'h308, 1'b1, 32'h3C0};
        tbl[18] = '{1'b1,1'b1,1'b0,1'b1, 32'h308, 32'h3C0, 32'h308, 1'b1, 32'h3C0};
        tbl[19] = '{1'b1,1'b1,1'b0,1'b1, 32'h308, 32'h3C0, 32'h308, 1'b1, 32'h3C0};
        tbl[20] = '{1'b1,1'b1,1'b0,1'b1, 32'h308, 32'h3C0, 32'h308, 1'b1, 32'h3C0};
        tbl[21] = '{1'b1,1'b1,1'b0,1'b0, 32'h308, 32'h3C0, 32'h308, 1'b1, 32'h3C0};
        tbl[22] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h308, 1'b1, 32'h3C0};
        tbl[23] = '{1'b1,1'b1,1'b0,1'b0, 32'h308, 32'h3C0, 32'h308, 1'b1, 32'h3C0};
        tbl[24] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h308, 1'b0, 32'h30C};
        tbl[25] = '{1'b1,1'b1,1'b0,1'b1, 32'h308, 32'h3C0, 32'h308, 1'b0, 32'h30C};
        tbl[26] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h308, 1'b1, 32'h3C0};
        tbl[27] = '{1'b1,1'b1,1'b0,1'b0, 32'h100, 32'h44,  32'h100, 1'b1, 32'h40};
        tbl[28] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h100, 1'b1, 32'h40};
        tbl[29] = '{1'b0,1'b1,1'b0,1'b1, 32'h400, 32'h500, 32'h400, 1'b0, 32'h404};
        tbl[30] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,   32'h400, 1'b0, 32'h404};

        for (int i = 0; i <= 30; i++) begin
            cyc(1'b0, tbl[i].uv, tbl[i].ib, tbl[i].ij, tbl[i].dt, tbl[i].pcu, tbl[i].tgt, tbl[i].pcfe);
`ifndef BP_GSHARE_EN
            chk($sformatf("tbl%0d_pred", i), obs_pred, tbl[i].ep);
            chk($sformatf("tbl%0d_pcnext", i), obs_next, tbl[i].en);
`endif
        end

        // History after T,T,N from a clean reset.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        sweep_wait();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h700, 32'h600);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h700, 32'h600);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h700, 32'h600);
        idle(32'h0);
`ifdef BP_GSHARE_EN
        exp_idx = 8'h06;
`else
        exp_idx = 8'h00;
`endif
        chk("bhr_index", obs_idx, exp_idx);

        // Reset while running with live BTB entries.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h40, 32'h100);
        idle(32'h100);
        chk("pre_rst_hit", obs_next, 32'h40);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
        for (int c = 0; c <= 257; c++) begin
            idle(32'h100);
            if (c == 0) chk("post_rst_ready", obs_ready, 1'b0);
            chk("post_rst_nohit", obs_next, 32'h104);
            if (c == 255) chk("resweep_c255", obs_ready, 1'b0);
            if (c == 256) chk("resweep_c256", obs_ready, 1'b1);
        end

        // Randomised traffic against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            uv = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 19))
                0, 1:    begin ib = 1'b1; ij = 1'b1; end
                2, 3, 4, 5, 6, 7, 8, 9, 10: begin ib = 1'b0; ij = 1'b1; end
                default: begin ib = 1'b1; ij = 1'b0; end
            endcase
            dt = ij ? 1'b1 : 1'($urandom);
            cyc(r, uv, ib, ij, dt, pick_pc(), pick_pc(), pick_pc());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
